seg_scan_mux: RTL and testbench

Parametrised time-multiplexed driver for a common-cathode or common-anode seven-segment bank of `DIGITS` hex digits, each with its own decimal point. It scans one digit at a time and inserts a programmable blanking gap between digits to suppress ghosting. Input data is latched once per frame so the display never tears. It sits between the application's BCD/hex value registers and the board's digit-select and segment pins. Everything runs on `clk` with an internal clock-enable counter; there are no derived clocks.

---
 rtl/seg_pkg.sv | 39 +++
 rtl/seg_hex_decode.sv | 19 +
 rtl/seg_scan_mux.sv | 207 ++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan driver.
// Hex glyph table (active-high gfedcba), FSM state enum, segment bit indices.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } seg_state_e;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry n is the glyph for nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] hex_glyph(
    input logic [3:0] nib,
    input logic       dp
  );
    logic [7:0] g;
    g = '0;
    g[SEG_G:SEG_A] = HEX_SEG[nib];
    g[SEG_DP] = dp;
    return g;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: nibble + dp + blank -> active-high segment byte.
// Ports: nib_i, dp_i, blank_i in; pat_o[7:0] out ([7]=dp, [6:0]=g..a).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] pat_o
);

  always_comb begin
    pat_o = '0;
    if (!blank_i) begin
      pat_o = hex_glyph(nib_i, dp_i);
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment driver, per-frame data latch.
// Ports: clk, rst_n, en, data, dp in; seg_sel, seg_led, frame_done out.
// Optional leading-zero suppression when SEG_LZ_BLANK_EN is defined.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int DIGIT_CYC    = 50_000,
  parameter int BLANK_CYC    = 500,
  parameter int SEL_ACT_HIGH = 1,
  parameter int SEG_ACT_HIGH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     seg_sel,
  output logic [7:0]            seg_led,
  output logic                  frame_done
);

  localparam int MAXC =
    (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
  localparam int TW = (MAXC > 0) ? $clog2(MAXC + 1) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BL = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  localparam logic [TW-1:0] D_LAST = TW'(DIGIT_CYC - 1);
  localparam logic [TW-1:0] B_LAST = TW'(BL);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  localparam logic [DIGITS-1:0] SEL_OFF =
    (SEL_ACT_HIGH != 0) ? '0 : '1;
  localparam logic [7:0] LED_OFF =
    (SEG_ACT_HIGH != 0) ? 8'h00 : 8'hFF;

  // After a lit digit (or from IDLE) the gap is skipped when empty.
  localparam seg_state_e GAP_ST =
    (BLANK_CYC == 0) ? SHOW : BLANK;

  seg_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0] dp_q, dp_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0] led_q, led_d;
  logic fd_q, fd_d;
  logic latch;

  // FSM next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    fd_d    = 1'b0;
    latch   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          latch   = 1'b1;
          idx_d   = '0;
          tmr_d   = '0;
          state_d = GAP_ST;
        end
        BLANK: begin
          if (tmr_q == B_LAST) begin
            tmr_d   = '0;
            state_d = SHOW;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        SHOW: begin
          if (tmr_q == D_LAST) begin
            tmr_d   = '0;
            state_d = GAP_ST;
            if (idx_q == I_LAST) begin
              idx_d = '0;
              fd_d  = 1'b1;
              latch = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_d = data_q;
    dp_d   = dp_q;
    if (latch) begin
      data_d = data;
      dp_d   = dp;
    end
  end

  logic blank_b;

`ifdef SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] mask_q, mask_d;
  logic [DIGITS-1:0] lz;
  logic lead;

  // Walk down from the top digit; stop at first
  // non-zero nibble or set dp. Digit 0 never blanks.
  always_comb begin
    lz   = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && data[4*i +: 4] == 4'h0 && !dp[i]) begin
        lz[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (latch) begin
      mask_d = lz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign blank_b = mask_d[idx_d];
`else
  assign blank_b = 1'b0;
`endif

  logic [3:0] nib;
  logic       dpb;
  logic [7:0] pat;
  logic [DIGITS-1:0] onehot;

  // Outputs are decoded from next-state values so they
  // change on the same edge the FSM enters a state.
  assign nib = data_d[{idx_d, 2'b00} +: 4];
  assign dpb = dp_d[idx_d];

  seg_hex_decode u_dec (
    .nib_i   (nib),
    .dp_i    (dpb),
    .blank_i (blank_b),
    .pat_o   (pat)
  );

  always_comb begin
    onehot = '0;
    onehot[idx_d] = 1'b1;
    sel_d = SEL_OFF;
    led_d = LED_OFF;
    if (state_d == SHOW) begin
      sel_d = (SEL_ACT_HIGH != 0) ? onehot : ~onehot;
      led_d = (SEG_ACT_HIGH != 0) ? pat : ~pat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      sel_q   <= SEL_OFF;
      led_q   <= LED_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
      fd_q    <= fd_d;
    end
  end

  assign seg_sel    = sel_q;
  assign seg_led    = led_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for seg_scan_mux.
// Two instances: default polarity (u0) and active-low polarity (u1).
module tb_seg_scan_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en0, en1;
  logic [15:0] data0, data1;
  logic [3:0]  dp0, dp1;
  logic [3:0]  sel0, sel1;
  logic [7:0]  led0, led1;
  logic        fd0, fd1;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] Z3F = 8'h00;
  localparam logic [7:0] ZC0 = 8'hFF;
`else
  localparam logic [7:0] Z3F = 8'h3F;
  localparam logic [7:0] ZC0 = 8'hC0;
`endif

  seg_scan_mux #(
    .DIGITS(4), .DIGIT_CYC(8), .BLANK_CYC(2),
    .SEL_ACT_HIGH(1), .SEG_ACT_HIGH(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .en(en0),
    .data(data0), .dp(dp0),
    .seg_sel(sel0), .seg_led(led0), .frame_done(fd0)
  );

  seg_scan_mux #(
    .DIGITS(4), .DIGIT_CYC(8), .BLANK_CYC(2),
    .SEL_ACT_HIGH(0), .SEG_ACT_HIGH(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1),
    .data(data1), .dp(dp1),
    .seg_sel(sel1), .seg_led(led1), .frame_done(fd1)
  );

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [7:0] led;
    logic       fd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc++;

  task automatic push(input bit u, input int c,
                      input logic [3:0] s,
                      input logic [7:0] l,
                      input logic f);
    exp_t e;
    e = '{c, s, l, f};
    if (u) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  // One frame: per digit 2 dark cycles then 8 lit.
  task automatic push_frame(input bit u, input int base,
                            input int n,
                            input logic [31:0] leds,
                            input bit fd);
    int k;
    logic [3:0] oh;
    k = 0;
    for (int d = 0; d < 4; d++) begin
      for (int b = 0; b < 2; b++) begin
        if (k < n)
          push(u, base + 1 + k, u ? 4'hF : 4'h0,
               u ? 8'hFF : 8'h00, fd && d == 0 && b == 0);
        k++;
      end
      oh = 4'b0001 << d;
      for (int s = 0; s < 8; s++) begin
        if (k < n)
          push(u, base + 1 + k, u ? ~oh : oh,
               leds[8*d +: 8], 1'b0);
        k++;
      end
    end
  endtask

  task automatic check(input exp_t e, input logic [3:0] s,
                       input logic [7:0] l, input logic f,
                       input string nm);
    checks++;
    if (e.cyc != cyc) begin
      failures++;
      $display("FAIL %s missed cyc: now=%0d want=%0d",
               nm, cyc, e.cyc);
    end else if (s !== e.sel || l !== e.led || f !== e.fd) begin
      failures++;
      $display("FAIL %s cyc=%0d got sel=%b led=%h fd=%b want sel=%b led=%h fd=%b",
               nm, cyc, s, l, f, e.sel, e.led, e.fd);
    end
  endtask

  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].cyc <= cyc)
      check(q0.pop_front(), sel0, led0, fd0, "u0");
    while (q1.size() > 0 && q1[0].cyc <= cyc)
      check(q1.pop_front(), sel1, led1, fd1, "u1");
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en0   = 1'b1;
    data0 = 16'h1234;
    dp0   = 4'b0010;
    for (int c = 1; c <= 4; c++) push(0, c, 4'h0, 8'h00, 1'b0);
    wait_cyc(4);
    rst_n = 1'b1;
    push_frame(0, 4, 40, {8'h06, 8'h5B, 8'hCF, 8'h66}, 1'b0);
    wait_cyc(19);
    data0 = 16'hABCD;
    push_frame(0, 44, 25, {8'h77, 8'h7C, 8'hB9, 8'h5E}, 1'b1);
    for (int c = 70; c <= 73; c++) push(0, c, 4'h0, 8'h00, 1'b0);
    wait_cyc(69);
    en0 = 1'b0;
    wait_cyc(73);
    en0 = 1'b1;
    push_frame(0, 73, 40, {8'h77, 8'h7C, 8'hB9, 8'h5E}, 1'b0);
    wait_cyc(80);
    data0 = 16'h0050;
    dp0   = 4'b0000;
    push_frame(0, 113, 40, {Z3F, Z3F, 8'h6D, 8'h3F}, 1'b1);
    wait_cyc(120);
    data0 = 16'h0000;
    push_frame(0, 153, 40, {Z3F, Z3F, Z3F, 8'h3F}, 1'b1);
    wait_cyc(200);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain left u0=%0d u1=%0d want 0",
               q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    en1   = 1'b0;
    data1 = 16'h0008;
    dp1   = 4'b0001;
    for (int c = 1; c <= 9; c++) push(1, c, 4'hF, 8'hFF, 1'b0);
    push_frame(1, 9, 40, {ZC0, ZC0, ZC0, 8'h00}, 1'b0);
    push_frame(1, 49, 12, {ZC0, ZC0, ZC0, 8'h00}, 1'b1);
    wait_cyc(9);
    en1 = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d want <=200", cyc);
    $fatal(1, "timeout");
  end

endmodule
